// File: rtl/pc_stack_sequencer_pkg.sv
// Shared types for the MCU program-flow sequencer: flow codes, FSM states, datapath widths.
package mcu_seq_pkg;

  localparam int PC_W   = 12;
  localparam int DATA_W = 16;

  localparam logic [3:0] FC_JMP   = 4'b0000;
  localparam logic [3:0] FC_JSR   = 4'b0001;
  localparam logic [3:0] FC_PUSHA = 4'b0010;
  localparam logic [3:0] FC_POPA  = 4'b0011;
  localparam logic [3:0] FC_RET   = 4'b0100;
  localparam logic [3:0] FC_SKIPC = 4'b0101;
  localparam logic [3:0] FC_SKIPZ = 4'b0110;
  localparam logic [3:0] FC_ION   = 4'b0111;
  localparam logic [3:0] FC_IOF   = 4'b1000;
  localparam logic [3:0] FC_HALT  = 4'b1001;
  localparam logic [3:0] FC_INC   = 4'b1111;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } seq_state_e;

  // Return addresses share the data stack, zero-extended to the data width.
  function automatic logic [DATA_W-1:0] ret_word(input logic [PC_W-1:0] addr);
    return {{(DATA_W-PC_W){1'b0}}, addr};
  endfunction

endpackage

// File: rtl/pc_stack_sequencer_if.sv
// Decoder <-> sequencer bundle; master = decoder side, slave = sequencer side.
interface pc_stack_sequencer_if
  import mcu_seq_pkg::*;
#(
  parameter int STACK_DEPTH = 16
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  logic              step;
  logic [3:0]        code;
  logic [PC_W-1:0]   branch_addr;
  logic [DATA_W-1:0] push_data;
  logic              irq;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic              irq_ack;
  logic              int_en;
  logic              halted;
  logic              stk_ovf;
  logic              stk_unf;
  logic [SP_W-1:0]   sp;

  modport master (
    output step, code, branch_addr, push_data, irq,
    input  pc, pop_data, pop_valid, irq_ack, int_en, halted, stk_ovf, stk_unf, sp
  );

  modport slave (
    input  step, code, branch_addr, push_data, irq,
    output pc, pop_data, pop_valid, irq_ack, int_en, halted, stk_ovf, stk_unf, sp
  );

endinterface

// File: rtl/pc_stack_sequencer_lifo.sv
// seq_lifo: DEPTH x W register-file stack; top entry read combinationally, 1-cycle update.
// No backpressure or error policy: push when full / pop when empty are silently dropped.
module seq_lifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] top_idx;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign top_idx = AW'(cnt_q - CW'(1));
  assign rdata_o = mem_q[top_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !full_o) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[cnt_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/pc_stack_sequencer.sv
// Program counter, call/data stack and halt/interrupt control; one flow code per cycle, results after the next edge.
// No backpressure: step is never stalled; stack faults halt until reset. Interrupt logic under `SEQ_IRQ_EN`.
module pc_stack_sequencer
  import mcu_seq_pkg::*;
#(
  parameter int              STACK_DEPTH = 16,
  parameter logic [PC_W-1:0] RESET_PC    = 12'h000,
  parameter logic [PC_W-1:0] ISR_VEC     = 12'hFF0
) (
  input logic                 clk,
  input logic                 rst,
  pc_stack_sequencer_if.slave bus
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  seq_state_e        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              pop_valid_q, pop_valid_d;
  logic              irq_ack_q, irq_ack_d;
  logic              int_en_q, int_en_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              lifo_push, lifo_pop, lifo_full, lifo_empty;
  logic [DATA_W-1:0] lifo_wdata, lifo_rdata;
  logic [SP_W-1:0]   lifo_count;

  seq_lifo #(
    .DEPTH (STACK_DEPTH),
    .W     (DATA_W)
  ) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (lifo_push),
    .pop_i   (lifo_pop),
    .wdata_i (lifo_wdata),
    .rdata_o (lifo_rdata),
    .full_o  (lifo_full),
    .empty_o (lifo_empty),
    .count_o (lifo_count)
  );

  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    irq_ack_d   = 1'b0;
    int_en_d    = int_en_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    lifo_push   = 1'b0;
    lifo_pop    = 1'b0;
    lifo_wdata  = '0;

    if (state_q == ST_RUN) begin
      if (bus.step) begin
        pc_d = pc_inc;
        case (bus.code)
          FC_JMP: pc_d = bus.branch_addr;
          FC_JSR, FC_PUSHA: begin
            if (lifo_full) begin
              ovf_d   = 1'b1;
              state_d = ST_HALTED;
              pc_d    = pc_q;
            end else begin
              lifo_push  = 1'b1;
              lifo_wdata = (bus.code == FC_JSR) ? ret_word(pc_inc) : bus.push_data;
              if (bus.code == FC_JSR) pc_d = bus.branch_addr;
            end
          end
          FC_POPA, FC_RET: begin
            if (lifo_empty) begin
              unf_d   = 1'b1;
              state_d = ST_HALTED;
              pc_d    = pc_q;
            end else begin
              lifo_pop = 1'b1;
              if (bus.code == FC_RET) begin
                pc_d = lifo_rdata[PC_W-1:0];
              end else begin
                pop_data_d  = lifo_rdata;
                pop_valid_d = 1'b1;
              end
            end
          end
          FC_SKIPC, FC_SKIPZ: pc_d = pc_q + PC_W'(2);
`ifdef SEQ_IRQ_EN
          FC_ION: int_en_d = 1'b1;
          FC_IOF: int_en_d = 1'b0;
`endif
          FC_HALT: begin
            state_d = ST_HALTED;
            pc_d    = pc_q;
          end
          default: pc_d = pc_inc;
        endcase
      end else begin
`ifdef SEQ_IRQ_EN
        // A full stack simply defers entry; irq stays pending without a fault.
        if (bus.irq && int_en_q && !lifo_full) begin
          lifo_push  = 1'b1;
          lifo_wdata = ret_word(pc_q);
          pc_d       = ISR_VEC;
          int_en_d   = 1'b0;
          irq_ack_d  = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      irq_ack_q   <= 1'b0;
      int_en_q    <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      irq_ack_q   <= irq_ack_d;
      int_en_q    <= int_en_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pop_data  = pop_data_q;
  assign bus.pop_valid = pop_valid_q;
  assign bus.irq_ack   = irq_ack_q;
  assign bus.int_en    = int_en_q;
  assign bus.halted    = (state_q == ST_HALTED);
  assign bus.stk_ovf   = ovf_q;
  assign bus.stk_unf   = unf_q;
  assign bus.sp        = lifo_count;

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Bench for pc_stack_sequencer: directed scenarios plus random flow codes against a queue-based model.
module tb_pc_stack_sequencer;
  import mcu_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int SP_W  = $clog2(DEPTH) + 1;
  localparam int VW    = 12 + SP_W + 16 + 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_stack_sequencer_if #(.STACK_DEPTH(DEPTH)) bus ();

  pc_stack_sequencer #(
    .STACK_DEPTH (DEPTH),
    .RESET_PC    (12'h000),
    .ISR_VEC     (12'hFF0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  int          m_pc;
  bit          m_halted, m_ovf, m_unf, m_int_en, m_pop_valid, m_irq_ack;
  logic [15:0] m_pop_data;
  logic [15:0] m_stk[$];

  function automatic void model_reset();
    m_pc = 0; m_halted = 0; m_ovf = 0; m_unf = 0; m_int_en = 0;
    m_pop_valid = 0; m_irq_ack = 0; m_pop_data = 16'h0;
    m_stk.delete();
  endfunction

  function automatic void model_step(input bit s, input logic [3:0] c, input logic [11:0] ba,
                                     input logic [15:0] pd, input bit ir);
    logic [15:0] v;
    m_pop_valid = 0;
    m_irq_ack   = 0;
    if (m_halted) return;
    if (s) begin
      if ((c == 4'b0001 || c == 4'b0010) && m_stk.size() == DEPTH) begin
        m_ovf = 1; m_halted = 1;
      end else if ((c == 4'b0011 || c == 4'b0100) && m_stk.size() == 0) begin
        m_unf = 1; m_halted = 1;
      end else begin
        case (c)
          4'b0000: m_pc = ba;
          4'b0001: begin m_stk.push_back(16'((m_pc + 1) % 4096)); m_pc = ba; end
          4'b0010: begin m_stk.push_back(pd); m_pc = (m_pc + 1) % 4096; end
          4'b0011: begin m_pop_data = m_stk.pop_back(); m_pop_valid = 1; m_pc = (m_pc + 1) % 4096; end
          4'b0100: begin v = m_stk.pop_back(); m_pc = v % 4096; end
          4'b0101, 4'b0110: m_pc = (m_pc + 2) % 4096;
          4'b1001: m_halted = 1;
          default: begin
`ifdef SEQ_IRQ_EN
            if (c == 4'b0111) m_int_en = 1;
            if (c == 4'b1000) m_int_en = 0;
`endif
            m_pc = (m_pc + 1) % 4096;
          end
        endcase
      end
    end else begin
`ifdef SEQ_IRQ_EN
      if (ir && m_int_en && m_stk.size() < DEPTH) begin
        m_stk.push_back(16'(m_pc));
        m_pc = 12'hFF0; m_int_en = 0; m_irq_ack = 1;
      end
`endif
    end
  endfunction

  task automatic cycle(input bit s, input logic [3:0] c, input logic [11:0] ba,
                       input logic [15:0] pd, input bit ir);
    bus.step = s; bus.code = c; bus.branch_addr = ba; bus.push_data = pd; bus.irq = ir;
    @(posedge clk);
    model_step(s, c, ba, pd, ir);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.step = 0; bus.code = 4'hF; bus.branch_addr = 12'h0; bus.push_data = 16'h0; bus.irq = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    cycle(1, FC_JMP, 12'h11E, 16'h0, 0);
    cycle(1, FC_PUSHA, 12'h0, 16'h1111, 0);
    cycle(1, FC_PUSHA, 12'h0, 16'h2222, 0);
    cycle(1, FC_POPA, 12'h0, 16'h0, 0);
    cycle(1, FC_PUSHA, 12'h0, 16'h3333, 0);
    cycle(1, FC_PUSHA, 12'h0, 16'h4444, 0);
    checks++;
    if (bus.pc !== 12'h123 || bus.sp !== SP_W'(3) || bus.pop_data !== 16'h2222) begin
      failures++;
      $display("FAIL reset_setup: pc=%h sp=%0d pop_data=%h, want pc=123 sp=3 pop_data=2222", bus.pc, bus.sp, bus.pop_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.pc, bus.sp, bus.pop_data, bus.pop_valid, bus.irq_ack, bus.int_en, bus.halted, bus.stk_ovf, bus.stk_unf} !== '0) begin
      failures++;
      $display("FAIL reset_async: pc=%h sp=%0d pop_data=%h flags=%b%b%b%b%b%b, want all zero", bus.pc, bus.sp,
               bus.pop_data, bus.pop_valid, bus.irq_ack, bus.int_en, bus.halted, bus.stk_ovf, bus.stk_unf);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_call_ret();
    do_reset();
    cycle(1, FC_JMP, 12'h010, 16'h0, 0);
    cycle(1, FC_JSR, 12'h200, 16'h0, 0);
    checks++;
    if (bus.pc !== 12'h200 || bus.sp !== SP_W'(1)) begin
      failures++;
      $display("FAIL jsr: pc=%h sp=%0d, want pc=200 sp=1", bus.pc, bus.sp);
    end
    cycle(1, FC_PUSHA, 12'h0, 16'hBEEF, 0);
    cycle(1, FC_POPA, 12'h0, 16'h0, 0);
    checks++;
    if (bus.pop_data !== 16'hBEEF || bus.pop_valid !== 1'b1 || bus.pc !== 12'h202) begin
      failures++;
      $display("FAIL popa: pop_data=%h pop_valid=%b pc=%h, want BEEF 1 202", bus.pop_data, bus.pop_valid, bus.pc);
    end
    cycle(0, FC_INC, 12'h0, 16'h0, 0);
    checks++;
    if (bus.pop_valid !== 1'b0 || bus.pc !== 12'h202) begin
      failures++;
      $display("FAIL pop_valid_pulse: pop_valid=%b pc=%h, want 0 202", bus.pop_valid, bus.pc);
    end
    cycle(1, FC_RET, 12'h0, 16'h0, 0);
    checks++;
    if (bus.pc !== 12'h011 || bus.sp !== SP_W'(0) || bus.halted !== 1'b0) begin
      failures++;
      $display("FAIL ret: pc=%h sp=%0d halted=%b, want 011 0 0", bus.pc, bus.sp, bus.halted);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1, FC_JSR, 12'(i * 256), 16'h0, 0);
    checks++;
    if (bus.pc !== 12'h400 || bus.sp !== SP_W'(4) || bus.stk_ovf !== 1'b0) begin
      failures++;
      $display("FAIL fill: pc=%h sp=%0d ovf=%b, want 400 4 0", bus.pc, bus.sp, bus.stk_ovf);
    end
    cycle(1, FC_JSR, 12'h500, 16'h0, 0);
    checks++;
    if (bus.stk_ovf !== 1'b1 || bus.halted !== 1'b1 || bus.pc !== 12'h400 || bus.sp !== SP_W'(4)) begin
      failures++;
      $display("FAIL overflow: ovf=%b halted=%b pc=%h sp=%0d, want 1 1 400 4", bus.stk_ovf, bus.halted, bus.pc, bus.sp);
    end
    cycle(1, FC_JMP, 12'h777, 16'h0, 0);
    cycle(1, FC_RET, 12'h0, 16'h0, 0);
    checks++;
    if (bus.pc !== 12'h400 || bus.sp !== SP_W'(4) || bus.halted !== 1'b1 || bus.stk_unf !== 1'b0) begin
      failures++;
      $display("FAIL halted_ignores_step: pc=%h sp=%0d halted=%b unf=%b, want 400 4 1 0", bus.pc, bus.sp, bus.halted, bus.stk_unf);
    end
  endtask

  task automatic test_underflow_wrap();
    do_reset();
    cycle(1, FC_RET, 12'h0, 16'h0, 0);
    checks++;
    if (bus.stk_unf !== 1'b1 || bus.halted !== 1'b1 || bus.pc !== 12'h000 || bus.pop_valid !== 1'b0) begin
      failures++;
      $display("FAIL underflow: unf=%b halted=%b pc=%h pop_valid=%b, want 1 1 000 0", bus.stk_unf, bus.halted, bus.pc, bus.pop_valid);
    end
    do_reset();
    cycle(1, FC_JMP, 12'hFFF, 16'h0, 0);
    cycle(1, FC_SKIPC, 12'h0, 16'h0, 0);
    checks++;
    if (bus.pc !== 12'h001) begin
      failures++;
      $display("FAIL skip_wrap: pc=%h, want 001", bus.pc);
    end
    cycle(1, FC_JMP, 12'hFFE, 16'h0, 0);
    cycle(1, FC_SKIPZ, 12'h0, 16'h0, 0);
    cycle(1, FC_INC, 12'h0, 16'h0, 0);
    checks++;
    if (bus.pc !== 12'h001) begin
      failures++;
      $display("FAIL inc_wrap: pc=%h, want 001", bus.pc);
    end
  endtask

`ifdef SEQ_IRQ_EN
  task automatic test_irq();
    do_reset();
    cycle(1, FC_JMP, 12'h050, 16'h0, 0);
    cycle(1, FC_ION, 12'h0, 16'h0, 0);
    cycle(0, FC_INC, 12'h0, 16'h0, 1);
    checks++;
    if (bus.pc !== 12'hFF0 || bus.int_en !== 1'b0 || bus.irq_ack !== 1'b1 || bus.sp !== SP_W'(1)) begin
      failures++;
      $display("FAIL irq_entry: pc=%h int_en=%b irq_ack=%b sp=%0d, want FF0 0 1 1", bus.pc, bus.int_en, bus.irq_ack, bus.sp);
    end
    cycle(0, FC_INC, 12'h0, 16'h0, 1);
    checks++;
    if (bus.irq_ack !== 1'b0 || bus.pc !== 12'hFF0) begin
      failures++;
      $display("FAIL irq_ack_pulse: irq_ack=%b pc=%h, want 0 FF0", bus.irq_ack, bus.pc);
    end
    cycle(1, FC_RET, 12'h0, 16'h0, 0);
    checks++;
    if (bus.pc !== 12'h051 || bus.int_en !== 1'b0) begin
      failures++;
      $display("FAIL irq_ret: pc=%h int_en=%b, want 051 0", bus.pc, bus.int_en);
    end
  endtask

  task automatic test_irq_priority();
    do_reset();
    cycle(1, FC_ION, 12'h0, 16'h0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, FC_INC, 12'h0, 16'h0, 1);
      checks++;
      if (bus.irq_ack !== 1'b0 || bus.int_en !== 1'b1 || bus.pc !== 12'(2 + i)) begin
        failures++;
        $display("FAIL irq_step_priority: irq_ack=%b int_en=%b pc=%h, want 0 1 %h", bus.irq_ack, bus.int_en, bus.pc, 12'(2 + i));
      end
    end
    cycle(0, FC_INC, 12'h0, 16'h0, 1);
    checks++;
    if (bus.irq_ack !== 1'b1 || bus.pc !== 12'hFF0 || bus.sp !== SP_W'(1)) begin
      failures++;
      $display("FAIL irq_after_step: irq_ack=%b pc=%h sp=%0d, want 1 FF0 1", bus.irq_ack, bus.pc, bus.sp);
    end
  endtask
`else
  task automatic test_irq_disabled();
    do_reset();
    cycle(1, FC_ION, 12'h0, 16'h0, 0);
    checks++;
    if (bus.int_en !== 1'b0 || bus.pc !== 12'h001) begin
      failures++;
      $display("FAIL ion_disabled: int_en=%b pc=%h, want 0 001", bus.int_en, bus.pc);
    end
    cycle(0, FC_INC, 12'h0, 16'h0, 1);
    checks++;
    if (bus.irq_ack !== 1'b0 || bus.pc !== 12'h001 || bus.sp !== SP_W'(0)) begin
      failures++;
      $display("FAIL irq_ignored: irq_ack=%b pc=%h sp=%0d, want 0 001 0", bus.irq_ack, bus.pc, bus.sp);
    end
  endtask
`endif

  task automatic test_random();
    logic [VW-1:0] obs, exp;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (m_halted && $urandom_range(0, 2) == 0) do_reset();
      cycle($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), 12'($urandom), 16'($urandom),
            $urandom_range(0, 1) == 1);
      obs = {bus.pc, bus.sp, bus.pop_data, bus.pop_valid, bus.irq_ack, bus.int_en, bus.halted, bus.stk_ovf, bus.stk_unf};
      exp = {12'(m_pc), SP_W'(m_stk.size()), m_pop_data, m_pop_valid, m_irq_ack, m_int_en, m_halted, m_ovf, m_unf};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL random[%0d]: got pc/sp/pop/flags=%h, want %h", n, obs, exp);
      end
    end
  endtask

  initial begin
    bus.step = 0; bus.code = 4'hF; bus.branch_addr = 12'h0; bus.push_data = 16'h0; bus.irq = 0;
    @(negedge clk);
    test_reset();
    test_call_ret();
    test_overflow();
    test_underflow_wrap();
`ifdef SEQ_IRQ_EN
    test_irq();
    test_irq_priority();
`else
    test_irq_disabled();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
